// File: rtl/param_register_file.sv
// Multi-port register file: DEPTH registers of WIDTH bits, every enabled register
// applies the same FunSel operation; two combinational read ports; sticky wrap flags.
module param_register_file #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEL_W = 3
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] I,
    input  logic [DEPTH-1:0] RegSel,
    input  logic [2:0]       FunSel,
    input  logic [SEL_W-1:0] OutASel,
    input  logic [SEL_W-1:0] OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [DEPTH-1:0] Wrap
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        FnDec   = 3'b000,
        FnInc   = 3'b001,
        FnLoad  = 3'b010,
        FnClear = 3'b011,
        FnHold  = 3'b100,
        FnShl   = 3'b101,
        FnShr   = 3'b110,
        FnSwap  = 3'b111
    } fun_e;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] wrap_q;
    logic [DEPTH-1:0] wrap_d;
    fun_e             fun;

    assign fun = fun_e'(FunSel);

    // RegSel is active-low: a 0 bit enables that register.
    always_comb begin
        wrap_d = wrap_q;
        for (int k = 0; k < DEPTH; k++) begin
            regs_d[k] = regs_q[k];
            if (!RegSel[k]) begin
                unique case (fun)
                    FnDec: begin
                        regs_d[k] = regs_q[k] - ONE;
                        if (~|regs_q[k]) wrap_d[k] = 1'b1;
                    end
                    FnInc: begin
                        regs_d[k] = regs_q[k] + ONE;
                        if (&regs_q[k]) wrap_d[k] = 1'b1;
                    end
                    FnLoad: begin
                        regs_d[k] = I;
                        wrap_d[k] = 1'b0;
                    end
                    FnClear: begin
                        regs_d[k] = '0;
                        wrap_d[k] = 1'b0;
                    end
                    FnHold:  regs_d[k] = regs_q[k];
                    FnShl:   regs_d[k] = {regs_q[k][WIDTH-2:0], 1'b0};
                    FnShr:   regs_d[k] = {1'b0, regs_q[k][WIDTH-1:1]};
                    FnSwap:  regs_d[k] = {regs_q[k][HALF-1:0], regs_q[k][WIDTH-1:HALF]};
                    default: regs_d[k] = regs_q[k];
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            wrap_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // Select-driven muxes; a select with no matching register leaves the port at zero.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (OutASel == SEL_W'(k)) OutA = regs_q[k];
            if (OutBSel == SEL_W'(k)) OutB = regs_q[k];
        end
    end

    assign Wrap = wrap_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench: default 16x8 instance plus a 32-bit, 6-deep instance.
`timescale 1ns / 1ps
module tb_param_register_file;

    logic        clk;
    logic        rst_n;

    logic [15:0] i16;
    logic [7:0]  regsel16;
    logic [2:0]  funsel16;
    logic [2:0]  asel16;
    logic [2:0]  bsel16;
    logic [15:0] outa16;
    logic [15:0] outb16;
    logic [7:0]  wrap16;

    logic [31:0] i32;
    logic [5:0]  regsel32;
    logic [2:0]  funsel32;
    logic [2:0]  asel32;
    logic [2:0]  bsel32;
    logic [31:0] outa32;
    logic [31:0] outb32;
    logic [5:0]  wrap32;

    int n_checks;
    int n_fail;

    param_register_file u_dut16 (
        .Clock   (clk),
        .Reset_n (rst_n),
        .I       (i16),
        .RegSel  (regsel16),
        .FunSel  (funsel16),
        .OutASel (asel16),
        .OutBSel (bsel16),
        .OutA    (outa16),
        .OutB    (outb16),
        .Wrap    (wrap16)
    );

    param_register_file #(
        .WIDTH (32),
        .DEPTH (6),
        .SEL_W (3)
    ) u_dut32 (
        .Clock   (clk),
        .Reset_n (rst_n),
        .I       (i32),
        .RegSel  (regsel32),
        .FunSel  (funsel32),
        .OutASel (asel32),
        .OutBSel (bsel32),
        .OutA    (outa32),
        .OutB    (outb32),
        .Wrap    (wrap32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a16(input logic [2:0] sel, output logic [15:0] val);
        asel16 = sel;
        #0.1;
        val = outa16;
    endtask

    task automatic read_b16(input logic [2:0] sel, output logic [15:0] val);
        bsel16 = sel;
        #0.1;
        val = outb16;
    endtask

    logic [15:0] v;
    logic [15:0] w;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        i16 = '0; regsel16 = '1; funsel16 = 3'b100; asel16 = '0; bsel16 = '0;
        i32 = '0; regsel32 = '1; funsel32 = 3'b100; asel32 = '0; bsel32 = '0;

        // Reset state
        #1;
        check_eq("rst_outa", 64'(outa16), 64'h0);
        check_eq("rst_wrap", 64'(wrap16), 64'h0);
        step();
        rst_n = 1'b1;

        // Load A5A5 into reg 2 only; no bypass before the edge
        i16 = 16'hA5A5; regsel16 = 8'b1111_1011; funsel16 = 3'b010;
        read_a16(3'd2, v);
        check_eq("load_nobypass", 64'(v), 64'h0);
        step();
        regsel16 = '1;
        read_a16(3'd2, v);
        check_eq("load_r2", 64'(v), 64'hA5A5);
        for (int k = 0; k < 8; k++) begin
            if (k != 2) begin
                read_b16(3'(k), v);
                check_eq($sformatf("load_other_r%0d", k), 64'(v), 64'h0);
            end
        end

        // Increment wrap on reg 5
        regsel16 = 8'b1101_1111; funsel16 = 3'b010; i16 = 16'hFFFF;
        step();
        funsel16 = 3'b001;
        step();
        read_a16(3'd5, v);
        check_eq("inc_wrap_val", 64'(v), 64'h0000);
        check_eq("inc_wrap_flag", 64'(wrap16), 64'h20);
        step();
        read_a16(3'd5, v);
        check_eq("inc_again_val", 64'(v), 64'h0001);
        check_eq("inc_again_flag", 64'(wrap16), 64'h20);
        funsel16 = 3'b010; i16 = 16'h0000;
        step();
        check_eq("load_clears_wrap", 64'(wrap16), 64'h0);

        // Decrement wrap and shift/swap chain on reg 0
        regsel16 = 8'b1111_1110; funsel16 = 3'b011;
        step();
        funsel16 = 3'b000;
        step();
        read_a16(3'd0, v);
        check_eq("dec_wrap_val", 64'(v), 64'hFFFF);
        check_eq("dec_wrap_flag", 64'(wrap16), 64'h01);
        funsel16 = 3'b110;
        step();
        read_a16(3'd0, v);
        check_eq("shr", 64'(v), 64'h7FFF);
        funsel16 = 3'b111;
        step();
        read_a16(3'd0, v);
        check_eq("swap", 64'(v), 64'hFF7F);
        funsel16 = 3'b101;
        step();
        read_a16(3'd0, v);
        check_eq("shl", 64'(v), 64'hFEFE);
        check_eq("shift_keeps_wrap", 64'(wrap16), 64'h01);

        // All disabled: nothing changes for any function
        regsel16 = '1;
        for (int f = 0; f < 8; f++) begin
            funsel16 = 3'(f);
            step();
        end
        read_a16(3'd0, v);
        check_eq("disabled_r0", 64'(v), 64'hFEFE);
        read_a16(3'd2, v);
        check_eq("disabled_r2", 64'(v), 64'hA5A5);
        check_eq("disabled_wrap", 64'(wrap16), 64'h01);

        // Multi-enable load of 1234
        regsel16 = 8'h00; funsel16 = 3'b010; i16 = 16'h1234;
        read_a16(3'd3, v);
        check_eq("multi_prev_r3", 64'(v), 64'h0);
        step();
        regsel16 = '1;
        for (int k = 0; k < 8; k++) begin
            read_a16(3'(k), v);
            read_b16(3'(7 - k), w);
            check_eq($sformatf("multi_a_r%0d", k), 64'(v), 64'h1234);
            check_eq($sformatf("multi_b_r%0d", 7 - k), 64'(w), 64'h1234);
        end
        check_eq("multi_wrap_cleared", 64'(wrap16), 64'h0);
        asel16 = 3'd4; bsel16 = 3'd4; #0.1;
        check_eq("same_sel", 64'(outb16), 64'(outa16));

        // 32-bit, 6-deep instance
        regsel32 = 6'b000000; funsel32 = 3'b010; i32 = 32'hDEADBEEF;
        step();
        regsel32 = '1;
        asel32 = 3'd7; bsel32 = 3'd5; #0.1;
        check_eq("w32_sel7_zero", 64'(outa32), 64'h0);
        check_eq("w32_r5_load", 64'(outb32), 64'hDEADBEEF);
        asel32 = 3'd6; #0.1;
        check_eq("w32_sel6_zero", 64'(outa32), 64'h0);
        regsel32 = 6'b011111; funsel32 = 3'b111;
        step();
        regsel32 = '1;
        asel32 = 3'd4; #0.1;
        check_eq("w32_r5_swap", 64'(outb32), 64'hBEEFDEAD);
        check_eq("w32_r4_kept", 64'(outa32), 64'hDEADBEEF);

        // Mid-burst reset on reg 1
        regsel16 = 8'b1111_1101; funsel16 = 3'b001; asel16 = 3'd1;
        step();
        step();
        step();
        check_eq("burst_r1", 64'(outa16), 64'h1237);
        rst_n = 1'b0;
        #0.5;
        check_eq("async_rst_outa", 64'(outa16), 64'h0);
        step();
        check_eq("rst_ignores_clk", 64'(outa16), 64'h0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            read_b16(3'(k), w);
            check_eq($sformatf("post_rst_r%0d", k), 64'(w), 64'h0);
        end
        check_eq("post_rst_wrap", 64'(wrap16), 64'h0);
        bsel32 = 3'd5; #0.1;
        check_eq("post_rst_w32", 64'(outb32), 64'h0);
        asel16 = 3'd1;
        step();
        check_eq("post_rst_inc", 64'(outa16), 64'h0001);
        read_b16(3'd0, w);
        check_eq("post_rst_r0_held", 64'(w), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
